// File: rtl/vector_serializer.sv
// Purpose : capture one packed vector of SIZE x WIDTH elements, stream them out one per transfer.
// Latency : first element valid the cycle after the load edge; eff_len cycles per vector at full rate.
// Backpr. : out_ready=0 freezes idx, buffer and all outputs; a new load is taken only when idle or on the last transfer.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   in_valid / in_ready     load handshake; data_in, len, reverse sampled on a load
//   data_in                 packed vector, element i = data_in[i]
//   len                     elements to emit (0 or >SIZE means SIZE)
//   reverse                 1 = emit from len-1 down to 0
//   out_valid / out_ready   element handshake
//   data_out, out_index     current element and its index (zero when idle)
//   out_last                current element is the final one of the vector
//   busy                    streaming in progress (same as out_valid)
module vector_serializer #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8,
    localparam int IW   = $clog2(SIZE),
    localparam int LW   = $clog2(SIZE + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SIZE-1:0][WIDTH-1:0]  data_in,
    input  logic [LW-1:0]               len,
    input  logic                        reverse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            data_out,
    output logic [IW-1:0]               out_index,
    output logic                        out_last,
    output logic                        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                       state;
    logic [SIZE-1:0][WIDTH-1:0]   vec_buf;
    logic [IW-1:0]                idx;
    logic [LW-1:0]                eff_len;
    logic                         rev;

    logic                         streaming;
    logic                         at_last;
    logic                         xfer;
    logic                         load;
    logic [LW-1:0]                load_len;
    logic [LW-1:0]                fwd_last_idx;

    // Out-of-range or zero length means "whole vector".
    assign load_len     = ((len == '0) || (len > LW'(SIZE))) ? LW'(SIZE) : len;
    assign fwd_last_idx = eff_len - LW'(1);

    assign streaming = (state == STREAM);
    assign at_last   = rev ? (idx == '0) : (LW'(idx) == fwd_last_idx);

    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_last  = streaming && at_last;
    assign data_out  = streaming ? vec_buf[idx] : '0;
    assign out_index = streaming ? idx : '0;

    assign xfer      = streaming && out_ready;
    // Accepting on the final transfer lets consecutive vectors stream with no bubble.
    assign in_ready  = !streaming || (xfer && at_last);
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            vec_buf <= '0;
            idx     <= '0;
            eff_len <= LW'(SIZE);
            rev     <= 1'b0;
        end else if (load) begin
            // A load on the last transfer takes priority over returning to IDLE.
            state   <= STREAM;
            vec_buf <= data_in;
            rev     <= reverse;
            eff_len <= load_len;
            idx     <= reverse ? IW'(load_len - LW'(1)) : '0;
        end else if (xfer) begin
            if (at_last) begin
                state <= IDLE;
            end else if (rev) begin
                idx <= idx - IW'(1);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Purpose : randomized plus directed stimulus against a queue-based model of the serializer.
// Latency : model predicts outputs each cycle from its pending-element queue.
// Backpr. : out_ready driven randomly / by fixed patterns; stalls must hold the head element.
module tb_vector_serializer;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int IW    = $clog2(SIZE);
    localparam int LW    = $clog2(SIZE + 1);

    typedef logic [SIZE-1:0][WIDTH-1:0] vec_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               i;
    } elem_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    vec_t                  data_in;
    logic [LW-1:0]         len;
    logic                  reverse;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      data_out;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    elem_t            q[$];     // elements still to be emitted, head = current
    logic [WIDTH-1:0] got[$];   // elements actually transferred

    vector_serializer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .len       (len),
        .reverse   (reverse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Build the expected element list straight from the load rules.
    task automatic model_load(input vec_t d, input logic [LW-1:0] l, input logic r);
        int eff;
        elem_t e;
        eff = (l == 0 || l > SIZE) ? SIZE : int'(l);
        q.delete();
        for (int k = 0; k < eff; k++) begin
            e.i = r ? (eff - 1 - k) : k;
            e.d = d[e.i];
            q.push_back(e);
        end
    endtask

    task automatic step(input logic iv, input vec_t d, input logic [LW-1:0] l,
                        input logic r, input logic ordy);
        logic ev;
        logic erdy;
        @(negedge clk);
        in_valid  = iv;
        data_in   = d;
        len       = l;
        reverse   = r;
        out_ready = ordy;
        #1;
        ev   = (q.size() != 0);
        erdy = !ev || (ordy && q.size() == 1);
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("busy",      32'(busy),      32'(ev));
        chk("in_ready",  32'(in_ready),  32'(erdy));
        chk("data_out",  32'(data_out),  ev ? 32'(q[0].d) : 32'd0);
        chk("out_index", 32'(out_index), ev ? 32'(q[0].i) : 32'd0);
        chk("out_last",  32'(out_last),  32'(ev && q.size() == 1));
        @(posedge clk);
        if (ev && ordy) begin
            got.push_back(q[0].d);
            void'(q.pop_front());
        end
        if (iv && erdy) model_load(d, l, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        vec_t rv;
        logic [WIDTH-1:0] seq[$];
        v1 = {8'h44, 8'h33, 8'h22, 8'h11};
        v2 = {8'h0D, 8'h0C, 8'h0B, 8'h0A};

        reset = 1'b1; in_valid = 1'b0; data_in = '0; len = '0; reverse = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Forward, full length.
        got.delete();
        step(1'b1, v1, 3'd4, 1'b0, 1'b1);
        idle(5);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("fwd_count", 32'(got.size()), 32'd4);
        foreach (seq[k]) if (k < got.size()) chk("fwd_seq", 32'(got[k]), 32'(seq[k]));

        // Reverse, len=3.
        got.delete();
        step(1'b1, v1, 3'd3, 1'b1, 1'b1);
        idle(4);
        seq = '{8'h33, 8'h22, 8'h11};
        chk("rev_count", 32'(got.size()), 32'd3);
        foreach (seq[k]) if (k < got.size()) chk("rev_seq", 32'(got[k]), 32'(seq[k]));

        // Zero and oversized length both mean SIZE.
        got.delete();
        step(1'b1, v1, 3'd0, 1'b0, 1'b1);
        idle(5);
        chk("len0_count", 32'(got.size()), 32'd4);
        got.delete();
        step(1'b1, v1, 3'd7, 1'b1, 1'b1);
        idle(5);
        chk("len7_count", 32'(got.size()), 32'd4);

        // Backpressure pattern 1,0,0,1,1,1.
        got.delete();
        step(1'b1, v1, 3'd4, 1'b0, 1'b1);
        step(1'b0, v1, 3'd4, 1'b0, 1'b1);
        step(1'b0, v1, 3'd4, 1'b0, 1'b0);
        step(1'b0, v1, 3'd4, 1'b0, 1'b0);
        step(1'b0, v1, 3'd4, 1'b0, 1'b1);
        step(1'b0, v1, 3'd4, 1'b0, 1'b1);
        step(1'b0, v1, 3'd4, 1'b0, 1'b1);
        idle(1);
        chk("bp_count", 32'(got.size()), 32'd4);

        // Back-to-back: in_valid held high through the stream.
        got.delete();
        step(1'b1, v1, 3'd4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, v2, 3'd4, 1'b0, 1'b1);
        idle(5);
        chk("b2b_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("b2b_seam_a", 32'(got[3]), 32'h44);
            chk("b2b_seam_b", 32'(got[4]), 32'h0A);
        end

        // Asynchronous reset while element 22 is presented.
        step(1'b1, v1, 3'd4, 1'b0, 1'b1);
        step(1'b0, v1, 3'd4, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("pre_rst_data", 32'(data_out), 32'h22);
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_data_out",  32'(data_out),  32'd0);
        chk("arst_out_index", 32'(out_index), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        got.delete();
        step(1'b1, v1, 3'd4, 1'b0, 1'b1);
        idle(5);
        chk("post_rst_count", 32'(got.size()), 32'd4);
        if (got.size() > 0) chk("post_rst_first", 32'(got[0]), 32'h11);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < SIZE; j++) rv[j] = WIDTH'($urandom);
            step(($urandom_range(0, 1) == 1), rv, LW'($urandom_range(0, 7)),
                 1'($urandom), ($urandom_range(0, 9) < 7));
        end
        idle(SIZE + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
